// File: rtl/uart_tx_pkg.sv
// -----------------------------------------------------------------------------
// uart_tx_pkg
//   Shared definitions for the UART transmitter:
//     - 2-bit baud-rate codes (BAUD_2400 .. BAUD_19200)
//     - 2-bit parity codes (PAR_NONE, PAR_ODD, PAR_EVEN, PAR_EXT)
//     - transmitter state encoding
//     - baud_div(): rounded clock divisor for a given system clock and baud
//     - baud_of(): baud rate in bits/s selected by a baud code
//   No ports; imported by uart_tx and uart_tx_baud_gen.
// -----------------------------------------------------------------------------
package uart_tx_pkg;

  localparam logic [1:0] BAUD_2400  = 2'b00;
  localparam logic [1:0] BAUD_4800  = 2'b01;
  localparam logic [1:0] BAUD_9600  = 2'b10;
  localparam logic [1:0] BAUD_19200 = 2'b11;

  // PAR_EXT: the parity is computed and presented on p_parity_out only;
  // no parity bit goes on the line.
  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_ODD  = 2'b01;
  localparam logic [1:0] PAR_EVEN = 2'b10;
  localparam logic [1:0] PAR_EXT  = 2'b11;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  // Round-to-nearest divisor: (f + b/2) / b.
  function automatic int baud_div(input int clk_freq, input int baud);
    return (clk_freq + baud / 2) / baud;
  endfunction

  function automatic int baud_of(input logic [1:0] code);
    case (code)
      BAUD_2400: return 2400;
      BAUD_4800: return 4800;
      BAUD_9600: return 9600;
      default:   return 19200;
    endcase
  endfunction

endpackage

// File: rtl/uart_tx_baud_gen.sv
// -----------------------------------------------------------------------------
// uart_tx_baud_gen
//   Bit-period timer. Counts 0 .. DIV-1 for the selected baud code and emits
//   a one-clock tick on the last count, so every bit lasts exactly DIV clocks.
//
//   Parameters
//     CLK_FREQ  system clock frequency in Hz
//     DIV_W     counter width; must hold the largest divisor minus one
//
//   Ports
//     clock      in   system clock, rising edge
//     rst        in   asynchronous active-low reset
//     baud_code  in   latched 2-bit baud code
//     clear      in   holds the counter at 0 (tick suppressed)
//     tick       out  high on the final clock of each bit period
// -----------------------------------------------------------------------------
module uart_tx_baud_gen
  import uart_tx_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int DIV_W    = 15
) (
  input  logic       clock,
  input  logic       rst,
  input  logic [1:0] baud_code,
  input  logic       clear,
  output logic       tick
);

  // Terminal counts (divisor minus one) for each rate, fixed at elaboration.
  localparam logic [DIV_W-1:0] LAST_2400  =
    DIV_W'(baud_div(CLK_FREQ, baud_of(BAUD_2400)) - 1);
  localparam logic [DIV_W-1:0] LAST_4800  =
    DIV_W'(baud_div(CLK_FREQ, baud_of(BAUD_4800)) - 1);
  localparam logic [DIV_W-1:0] LAST_9600  =
    DIV_W'(baud_div(CLK_FREQ, baud_of(BAUD_9600)) - 1);
  localparam logic [DIV_W-1:0] LAST_19200 =
    DIV_W'(baud_div(CLK_FREQ, baud_of(BAUD_19200)) - 1);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] last_cnt;

  always_comb begin
    last_cnt = LAST_19200;
    case (baud_code)
      BAUD_2400: last_cnt = LAST_2400;
      BAUD_4800: last_cnt = LAST_4800;
      BAUD_9600: last_cnt = LAST_9600;
      default:   last_cnt = LAST_19200;
    endcase
  end

  // Combinational tick so the FSM advances on the same edge the count wraps.
  assign tick = !clear && (cnt == last_cnt);

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clear || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx
//   UART transmitter. A rising edge of send while idle latches one 7- or 8-bit
//   character plus its framing options and shifts out
//   start / data (LSB first) / [parity] / stop(s) on data_out.
//
//   Optional feature macro: UART_TX_PARITY_EN
//     defined   - odd/even line parity and p_parity_out are active
//     undefined - parity_type is ignored, no parity bit is ever sent and
//                 p_parity_out is tied low
//
//   Parameters
//     CLK_FREQ  system clock in Hz (sets the baud divisors)
//     DIV_W     width of the bit-period counter
//
//   Ports
//     clock        in   system clock, rising edge
//     rst          in   asynchronous active-low reset
//     send         in   transmit request, rising-edge triggered
//     baud_rate    in   00=2400 01=4800 10=9600 11=19200
//     data_in      in   character, bit 0 sent first (bit 7 unused for 7 bits)
//     parity_type  in   00=none 01=odd 10=even 11=parity on p_parity_out only
//     stop_bits    in   0=one stop bit, 1=two
//     data_length  in   0=7 data bits, 1=8
//     data_out     out  serial line, idles high
//     p_parity_out out  XOR of the latched data bits
//     tx_active    out  high while a frame is on the line
//     tx_done      out  one-clock pulse at frame end
// -----------------------------------------------------------------------------
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int DIV_W    = 15
) (
  input  logic       clock,
  input  logic       rst,
  input  logic       send,
  input  logic [1:0] baud_rate,
  input  logic [7:0] data_in,
  input  logic [1:0] parity_type,
  input  logic       stop_bits,
  input  logic       data_length,
  output logic       data_out,
  output logic       p_parity_out,
  output logic       tx_active,
  output logic       tx_done
);

  // Even parity over the bits actually transmitted.
  function automatic logic parity_of(input logic [7:0] d, input logic len8);
    return len8 ? ^d : ^d[6:0];
  endfunction

  tx_state_t  state;
  logic       send_q;
  logic       start;
  logic       tick;
  logic [2:0] bit_idx;
  logic [2:0] last_idx;
  logic       stop_cnt;

  // Frame configuration captured at start; never reset since it is only
  // consumed outside IDLE, after a start has loaded it.
  logic [7:0] data_l;
  logic [1:0] baud_l;
  logic       stop2_l;
  logic       len8_l;

  logic       use_parity;
  logic       parity_bit;

`ifdef UART_TX_PARITY_EN
  logic [1:0] par_l;
  logic       par_q;

  assign use_parity   = (par_l == PAR_ODD) || (par_l == PAR_EVEN);
  assign parity_bit   = (par_l == PAR_ODD) ? ~par_q : par_q;
  assign p_parity_out = par_q;
`else
  logic unused_parity_type;

  assign unused_parity_type = ^parity_type;
  assign use_parity         = 1'b0;
  assign parity_bit         = 1'b0;
  assign p_parity_out       = 1'b0;
`endif

  assign start    = send && !send_q && (state == IDLE);
  assign last_idx = len8_l ? 3'd7 : 3'd6;

  uart_tx_baud_gen #(
    .CLK_FREQ (CLK_FREQ),
    .DIV_W    (DIV_W)
  ) u_baud_gen (
    .clock     (clock),
    .rst       (rst),
    .baud_code (baud_l),
    .clear     (state == IDLE),
    .tick      (tick)
  );

  // ---- frame configuration capture ----
  always_ff @(posedge clock) begin
    if (start) begin
      data_l  <= data_in;
      baud_l  <= baud_rate;
      stop2_l <= stop_bits;
      len8_l  <= data_length;
`ifdef UART_TX_PARITY_EN
      par_l   <= parity_type;
`endif
    end
  end

  // ---- transmit FSM ----
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      send_q    <= 1'b0;
      data_out  <= 1'b1;
      tx_active <= 1'b0;
      tx_done   <= 1'b0;
      bit_idx   <= 3'd0;
      stop_cnt  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      send_q  <= send;
      tx_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
`ifdef UART_TX_PARITY_EN
            par_q     <= parity_of(data_in, data_length);
`endif
            tx_active <= 1'b1;
            data_out  <= 1'b0;
            state     <= START;
          end
        end

        START: begin
          if (tick) begin
            data_out <= data_l[0];
            bit_idx  <= 3'd0;
            state    <= DATA;
          end
        end

        DATA: begin
          if (tick) begin
            if (bit_idx == last_idx) begin
              if (use_parity) begin
                data_out <= parity_bit;
                state    <= PARITY;
              end else begin
                data_out <= 1'b1;
                stop_cnt <= 1'b0;
                state    <= STOP;
              end
            end else begin
              bit_idx  <= bit_idx + 3'd1;
              data_out <= data_l[bit_idx + 3'd1];
            end
          end
        end

        PARITY: begin
          if (tick) begin
            data_out <= 1'b1;
            stop_cnt <= 1'b0;
            state    <= STOP;
          end
        end

        STOP: begin
          if (tick) begin
            // Two stop bits are simply two back-to-back stop periods.
            if (stop2_l && !stop_cnt) begin
              stop_cnt <= 1'b1;
            end else begin
              tx_active <= 1'b0;
              tx_done   <= 1'b1;
              state     <= IDLE;
            end
          end
        end

        default: begin
          data_out  <= 1'b1;
          tx_active <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_tx
//   Directed bench for uart_tx. The clock is scaled to 96 kHz so the baud
//   divisors are small: 2400 -> 40, 4800 -> 20, 9600 -> 10, 19200 -> 5 clocks.
//   Expected line patterns are written as strings, first transmitted bit first.
// -----------------------------------------------------------------------------
module tb_uart_tx;

  localparam int CLK_FREQ = 96_000;
  localparam int D2400    = 40;
  localparam int D4800    = 20;
  localparam int D9600    = 10;
  localparam int D19200   = 5;

  logic       clock = 1'b0;
  logic       rst   = 1'b0;
  logic       send  = 1'b0;
  logic [1:0] baud_rate = 2'b00;
  logic [7:0] data_in = 8'h00;
  logic [1:0] parity_type = 2'b00;
  logic       stop_bits = 1'b0;
  logic       data_length = 1'b0;
  logic       data_out;
  logic       p_parity_out;
  logic       tx_active;
  logic       tx_done;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int hold     = 0;
  int retrig   = 0;
  logic saw_done;

  uart_tx #(
    .CLK_FREQ (CLK_FREQ),
    .DIV_W    (15)
  ) dut (
    .clock        (clock),
    .rst          (rst),
    .send         (send),
    .baud_rate    (baud_rate),
    .data_in      (data_in),
    .parity_type  (parity_type),
    .stop_bits    (stop_bits),
    .data_length  (data_length),
    .data_out     (data_out),
    .p_parity_out (p_parity_out),
    .tx_active    (tx_active),
    .tx_done      (tx_done)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock, sampled 1 time unit after the rising edge. Also drives the
  // send schedule and scrambles every input mid-frame.
  task automatic step();
    @(posedge clock);
    #1;
    cyc++;
    if (hold != 0 && cyc == hold) send = 1'b0;
    if (retrig != 0 && cyc == retrig) send = 1'b1;
    if (retrig != 0 && cyc == retrig + 3) send = 1'b0;
    if (cyc == 3) begin
      data_in     = ~data_in;
      baud_rate   = ~baud_rate;
      parity_type = ~parity_type;
      stop_bits   = ~stop_bits;
      data_length = ~data_length;
    end
  endtask

  // Starts a frame and checks every bit at its first and last clock, then
  // the frame-end pulse. Returns 1 time unit after the frame-end edge.
  task automatic run_frame(input string tag, input logic [1:0] br, input int div,
                           input logic [7:0] d, input logic [1:0] pt,
                           input logic sb, input logic dl, input string exp,
                           input logic exp_par, input int h, input int rt);
    logic b;
    @(negedge clock);
    baud_rate   = br;
    data_in     = d;
    parity_type = pt;
    stop_bits   = sb;
    data_length = dl;
    hold        = h;
    retrig      = rt;
    cyc         = 0;
    send        = 1'b1;
    @(posedge clock);
    #1;
    chk({tag, "_par"}, p_parity_out, exp_par);
    chk({tag, "_done_lo"}, tx_done, 1'b0);
    for (int i = 0; i < exp.len(); i++) begin
      b = (exp[i] == "1");
      chk($sformatf("%s_b%0d_first", tag, i), data_out, b);
      chk($sformatf("%s_b%0d_act", tag, i), tx_active, 1'b1);
      repeat (div - 1) step();
      chk($sformatf("%s_b%0d_last", tag, i), data_out, b);
      chk($sformatf("%s_b%0d_nodone", tag, i), tx_done, 1'b0);
      step();
    end
    chk({tag, "_done"}, tx_done, 1'b1);
    chk({tag, "_end_act"}, tx_active, 1'b0);
    chk({tag, "_end_line"}, data_out, 1'b1);
    chk({tag, "_par_hold"}, p_parity_out, exp_par);
  endtask

  initial begin
    // Reset values
    #12;
    chk("rst_line", data_out, 1'b1);
    chk("rst_act", tx_active, 1'b0);
    chk("rst_done", tx_done, 1'b0);
    chk("rst_par", p_parity_out, 1'b0);
    @(negedge clock);
    rst = 1'b1;
    repeat (3) step();
    chk("idle_line", data_out, 1'b1);
    chk("idle_act", tx_active, 1'b0);

    // 9600 8N1 0xAA, send held for 5 clocks
    run_frame("t1_9600_8n1", 2'b10, D9600, 8'hAA, 2'b00, 1'b0, 1'b1,
              "0010101011", 1'b0, 5, 0);

`ifdef UART_TX_PARITY_EN
    // Starts on the clock right after tx_done
    run_frame("t2_4800_7e2", 2'b01, D4800, 8'h66, 2'b10, 1'b1, 1'b0,
              "00110011011", 1'b0, 2, 0);
    run_frame("t3_2400_8o1", 2'b00, D2400, 8'h69, 2'b01, 1'b0, 1'b1,
              "01001011011", 1'b0, 2, 0);
`else
    run_frame("t2_4800_7e2", 2'b01, D4800, 8'h66, 2'b10, 1'b1, 1'b0,
              "0011001111", 1'b0, 2, 0);
    run_frame("t3_2400_8o1", 2'b00, D2400, 8'h69, 2'b01, 1'b0, 1'b1,
              "0100101101", 1'b0, 2, 0);
`endif

    // 19200, external parity, 8 bits, 2 stop; send held through frame end
    run_frame("t4_19200_ext", 2'b11, D19200, 8'hF0, 2'b11, 1'b1, 1'b1,
              "00000111111", 1'b0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      repeat (3) step();
      chk($sformatf("held_noretrig_act%0d", i), tx_active, 1'b0);
      chk($sformatf("held_noretrig_line%0d", i), data_out, 1'b1);
    end
    send = 1'b0;
    step();

`ifdef UART_TX_PARITY_EN
    // Fresh edge after the held send; a second edge mid-frame is ignored
    run_frame("t5_19200_8e1", 2'b11, D19200, 8'h07, 2'b10, 1'b0, 1'b1,
              "01110000011", 1'b1, 2, 30);
    run_frame("t6_9600_7o1", 2'b10, D9600, 8'h80, 2'b01, 1'b0, 1'b0,
              "0000000011", 1'b0, 2, 0);
`else
    run_frame("t5_19200_8e1", 2'b11, D19200, 8'h07, 2'b10, 1'b0, 1'b1,
              "0111000001", 1'b0, 2, 30);
    run_frame("t6_9600_7o1", 2'b10, D9600, 8'h80, 2'b01, 1'b0, 1'b0,
              "000000001", 1'b0, 2, 0);
`endif
    repeat (12) step();
    chk("after_ignored_edge_act", tx_active, 1'b0);

    // Reset during DATA aborts the frame with no tx_done
    @(negedge clock);
    baud_rate   = 2'b11;
    data_in     = 8'h07;
    parity_type = 2'b10;
    stop_bits   = 1'b0;
    data_length = 1'b1;
    hold        = 2;
    retrig      = 0;
    cyc         = 0;
    send        = 1'b1;
    @(posedge clock);
    #1;
    repeat (22) step();
    chk("mid_data_line", data_out, 1'b0);
    chk("mid_data_act", tx_active, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    chk("abort_line", data_out, 1'b1);
    chk("abort_act", tx_active, 1'b0);
    chk("abort_done", tx_done, 1'b0);
    chk("abort_par", p_parity_out, 1'b0);
    repeat (3) step();
    @(negedge clock);
    rst = 1'b1;
    saw_done = 1'b0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (tx_done === 1'b1 || tx_active === 1'b1 || data_out !== 1'b1) saw_done = 1'b1;
    end
    chk("abort_no_done_or_frame", saw_done, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
